// File: rtl/dft_bin_acc.sv
// Two-bin DFT correlator: multiplies one frame of RAM samples by two streamed NCO phasors,
// accumulates, then outputs saturated re/im and power per bin.
module dft_bin_acc #(
    parameter int N_SAMP  = 512,
    parameter int ADDR_W  = 9,
    parameter int NCO_LAT = 5,
    parameter int SHIFT   = 17,
    parameter int OUT_W   = 18
) (
    input  logic                    CK,
    input  logic                    RSTN,
    input  logic                    START,
    input  logic signed [17:0]      cos0,
    input  logic signed [17:0]      sin0,
    input  logic signed [17:0]      cos1,
    input  logic signed [17:0]      sin1,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic signed [15:0]      rd_data,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] re0,
    output logic signed [OUT_W-1:0] im0,
    output logic signed [OUT_W-1:0] re1,
    output logic signed [OUT_W-1:0] im1,
    output logic [2*OUT_W:0]        pow0,
    output logic [2*OUT_W:0]        pow1
);
    localparam int PROD_W = 34;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam int SQ_W   = 2 * OUT_W;
    localparam int FIN    = NCO_LAT + N_SAMP + 3;
    localparam int CNT_W  = $clog2(FIN + 1);

    localparam logic [CNT_W-1:0]  E_RD      = CNT_W'(NCO_LAT - 1);
    localparam logic [CNT_W-1:0]  E_ACC     = CNT_W'(NCO_LAT + N_SAMP + 1);
    localparam logic [CNT_W-1:0]  E_SAT     = CNT_W'(NCO_LAT + N_SAMP + 2);
    localparam logic [CNT_W-1:0]  E_FIN     = CNT_W'(FIN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMP - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    d_vld_q;
    logic                    p_vld_q;
    logic                    fin;
    logic signed [PROD_W-1:0] p_c0_q, p_s0_q, p_c1_q, p_s1_q;
    logic signed [ACC_W-1:0]  acc_re0_q, acc_im0_q, acc_re1_q, acc_im1_q;
    logic signed [OUT_W-1:0]  r_re0_q, r_im0_q, r_re1_q, r_im1_q;

    // Floor shift, then clamp to the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if ((&s[ACC_W-1:OUT_W-1]) || !(|s[ACC_W-1:OUT_W-1])) return s[OUT_W-1:0];
        if (s[ACC_W-1]) return {1'b1, {(OUT_W-1){1'b0}}};
        return {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    function automatic logic [2*OUT_W:0] pwr(input logic signed [OUT_W-1:0] a,
                                             input logic signed [OUT_W-1:0] b);
        logic signed [SQ_W-1:0] aa;
        logic signed [SQ_W-1:0] bb;
        aa = SQ_W'(a) * SQ_W'(a);
        bb = SQ_W'(b) * SQ_W'(b);
        return {1'b0, aa} + {1'b0, bb};
    endfunction

    assign cnt_nxt = cnt_q + CNT_W'(1);
    assign fin     = (state_q == S_OUT) && (cnt_nxt == E_FIN);

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            d_vld_q   <= 1'b0;
            p_vld_q   <= 1'b0;
            p_c0_q    <= '0;
            p_s0_q    <= '0;
            p_c1_q    <= '0;
            p_s1_q    <= '0;
            acc_re0_q <= '0;
            acc_im0_q <= '0;
            acc_re1_q <= '0;
            acc_im1_q <= '0;
            r_re0_q   <= '0;
            r_im0_q   <= '0;
            r_re1_q   <= '0;
            r_im1_q   <= '0;
            re0       <= '0;
            im0       <= '0;
            re1       <= '0;
            im1       <= '0;
            pow0      <= '0;
            pow1      <= '0;
        end else begin
            done <= fin;
            // Result publication is independent of a coincident START.
            if (fin) begin
                re0  <= r_re0_q;
                im0  <= r_im0_q;
                re1  <= r_re1_q;
                im1  <= r_im1_q;
                pow0 <= pwr(r_re0_q, r_im0_q);
                pow1 <= pwr(r_re1_q, r_im1_q);
            end
            if (START) begin
                state_q   <= S_WAIT;
                cnt_q     <= '0;
                busy      <= 1'b1;
                rd_en     <= 1'b0;
                rd_addr   <= '0;
                d_vld_q   <= 1'b0;
                p_vld_q   <= 1'b0;
                acc_re0_q <= '0;
                acc_im0_q <= '0;
                acc_re1_q <= '0;
                acc_im1_q <= '0;
            end else begin
                if (state_q != S_IDLE) cnt_q <= cnt_nxt;
                d_vld_q <= rd_en;
                p_vld_q <= d_vld_q;
                p_c0_q  <= PROD_W'(rd_data) * PROD_W'(cos0);
                p_s0_q  <= PROD_W'(rd_data) * PROD_W'(sin0);
                p_c1_q  <= PROD_W'(rd_data) * PROD_W'(cos1);
                p_s1_q  <= PROD_W'(rd_data) * PROD_W'(sin1);
                // Negative imaginary sum: correlation against e^-jwt.
                if (p_vld_q) begin
                    acc_re0_q <= acc_re0_q + ACC_W'(p_c0_q);
                    acc_im0_q <= acc_im0_q - ACC_W'(p_s0_q);
                    acc_re1_q <= acc_re1_q + ACC_W'(p_c1_q);
                    acc_im1_q <= acc_im1_q - ACC_W'(p_s1_q);
                end
                case (state_q)
                    S_IDLE: ;
                    S_WAIT: begin
                        if (cnt_nxt == E_RD) begin
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                            state_q <= S_FEED;
                        end
                    end
                    S_FEED: begin
                        if (rd_addr == LAST_ADDR) begin
                            rd_en   <= 1'b0;
                            state_q <= S_DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (cnt_nxt == E_ACC) state_q <= S_OUT;
                    end
                    S_OUT: begin
                        if (cnt_nxt == E_SAT) begin
                            r_re0_q <= sat(acc_re0_q);
                            r_im0_q <= sat(acc_im0_q);
                            r_re1_q <= sat(acc_re1_q);
                            r_im1_q <= sat(acc_im1_q);
                        end
                        if (fin) begin
                            busy    <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dft_bin_acc.sv
// Bench for dft_bin_acc: arithmetic DFT model of each frame plus a per-cycle output compare,
// with hand-computed literal cases and randomized frames, aborts and back-to-back starts.
module tb_dft_bin_acc;
    localparam int N   = 8;
    localparam int AW  = 3;
    localparam int LAT = 5;
    localparam int SH  = 17;
    localparam int OW  = 18;
    localparam int FIN = LAT + N + 3;

    logic CK = 1'b0;
    logic RSTN = 1'b0;
    logic START = 1'b0;
    logic signed [17:0] cos0 = '0, sin0 = '0, cos1 = '0, sin1 = '0;
    logic signed [15:0] rd_data = '0;
    logic rd_en, busy, done;
    logic [AW-1:0] rd_addr;
    logic signed [OW-1:0] re0, im0, re1, im1;
    logic [2*OW:0] pow0, pow1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int x_tab[N], c0_tab[N], s0_tab[N], c1_tab[N], s1_tab[N];

    always #5 CK = ~CK;

    dft_bin_acc #(.N_SAMP(N), .ADDR_W(AW), .NCO_LAT(LAT), .SHIFT(SH), .OUT_W(OW)) dut (
        .CK(CK), .RSTN(RSTN), .START(START),
        .cos0(cos0), .sin0(sin0), .cos1(cos1), .sin1(sin1),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done),
        .re0(re0), .im0(im0), .re1(re1), .im1(im1),
        .pow0(pow0), .pow1(pow1)
    );

    function automatic longint dot(input int a[N], input int b[N]);
        longint acc = 0;
        for (int k = 0; k < N; k++) acc += longint'(a[k]) * longint'(b[k]);
        return acc;
    endfunction

    function automatic longint satf(input longint a);
        longint s = a >>> SH;
        longint hi = (longint'(1) << (OW - 1)) - 1;
        if (s > hi) return hi;
        if (s < -hi - 1) return -hi - 1;
        return s;
    endfunction

    // Reference model: frame timeline relative to the START edge.
    logic   m_active, m_done, m_busy;
    int     m_edge;
    longint pend[4];
    longint m_out[6];

    always @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_busy   <= 1'b0;
            m_edge   <= 0;
            for (int i = 0; i < 6; i++) m_out[i] <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active && m_edge + 1 == FIN) begin
                m_done   <= 1'b1;
                m_busy   <= 1'b0;
                m_active <= 1'b0;
                for (int i = 0; i < 4; i++) m_out[i] <= pend[i];
                m_out[4] <= pend[0] * pend[0] + pend[1] * pend[1];
                m_out[5] <= pend[2] * pend[2] + pend[3] * pend[3];
            end else if (m_active) begin
                m_edge <= m_edge + 1;
            end
            if (START) begin
                m_active <= 1'b1;
                m_busy   <= 1'b1;
                m_edge   <= 0;
                pend[0]  <= satf(dot(x_tab, c0_tab));
                pend[1]  <= satf(-dot(x_tab, s0_tab));
                pend[2]  <= satf(dot(x_tab, c1_tab));
                pend[3]  <= satf(-dot(x_tab, s1_tab));
            end
        end
    end

    // NCO stand-in: phase k in cycle LAT+k, junk everywhere else.
    always @(negedge CK) begin
        if (m_active && m_edge >= LAT && m_edge < LAT + N) begin
            cos0 <= 18'(c0_tab[m_edge-LAT]);
            sin0 <= 18'(s0_tab[m_edge-LAT]);
            cos1 <= 18'(c1_tab[m_edge-LAT]);
            sin1 <= 18'(s1_tab[m_edge-LAT]);
        end else begin
            cos0 <= 18'($urandom);
            sin0 <= 18'($urandom);
            cos1 <= 18'($urandom);
            sin1 <= 18'($urandom);
        end
    end

    // Registered sample RAM; output is junk when not read.
    always @(posedge CK) begin
        if (rd_en) rd_data <= 16'(x_tab[rd_addr]);
        else       rd_data <= 16'($urandom);
    end

    logic exp_rd;
    assign exp_rd = m_active && (m_edge >= LAT - 1) && (m_edge <= LAT + N - 2);

    always @(negedge CK) begin
        if (chk_en) begin
            tests++;
            if (done != m_done || busy != m_busy || rd_en != exp_rd ||
                (exp_rd && int'(rd_addr) != m_edge - LAT + 1) ||
                longint'(re0) != m_out[0] || longint'(im0) != m_out[1] ||
                longint'(re1) != m_out[2] || longint'(im1) != m_out[3] ||
                longint'(pow0) != m_out[4] || longint'(pow1) != m_out[5]) begin
                fails++;
                $display({"FAIL cycle_cmp t=%0t (got/want) done %0d/%0d busy %0d/%0d ",
                          "rd_en %0d/%0d addr %0d/%0d re0 %0d/%0d im0 %0d/%0d re1 %0d/%0d ",
                          "im1 %0d/%0d pow0 %0d/%0d pow1 %0d/%0d"},
                         $time, done, m_done, busy, m_busy, rd_en, exp_rd, rd_addr,
                         m_edge - LAT + 1, re0, m_out[0], im0, m_out[1], re1, m_out[2],
                         im1, m_out[3], pow0, m_out[4], pow1, m_out[5]);
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic set_tabs(input int x, input int c0, input int s0, input int c1,
                            input int s1);
        for (int k = 0; k < N; k++) begin
            x_tab[k] = x; c0_tab[k] = c0; s0_tab[k] = s0; c1_tab[k] = c1; s1_tab[k] = s1;
        end
    endtask

    task automatic rand_tabs();
        for (int k = 0; k < N; k++) begin
            x_tab[k]  = int'($urandom_range(0, 65535)) - 32768;
            c0_tab[k] = int'($urandom_range(0, 262143)) - 131072;
            s0_tab[k] = int'($urandom_range(0, 262143)) - 131072;
            c1_tab[k] = int'($urandom_range(0, 262143)) - 131072;
            s1_tab[k] = int'($urandom_range(0, 262143)) - 131072;
        end
    endtask

    // Returns at the negedge after edge 0.
    task automatic start_pulse();
        START = 1'b1;
        @(negedge CK);
        START = 1'b0;
    endtask

    // Counts edges after edge 0; bounded, a timeout is a failed comparison.
    task automatic wait_done(output int done_edge, output int first_rd);
        done_edge = -1;
        first_rd  = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CK);
            if (rd_en && first_rd < 0) first_rd = n;
            if (done) begin
                done_edge = n;
                break;
            end
        end
        if (done_edge < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done, want done within 40 cycles");
        end
    endtask

    initial begin
        int de, fr;
        longint sv[5];
        RSTN = 1'b0;
        set_tabs(0, 0, 0, 0, 0);
        repeat (3) @(negedge CK);
        chk_en = 1'b1;
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_re0", re0, 0);
        check("rst_pow1", pow1, 0);
        RSTN = 1'b1;
        @(negedge CK);

        // DC into bin 0
        set_tabs(1000, 131071, 0, 0, 0);
        for (int k = 0; k < N; k++) begin
            c1_tab[k] = int'($urandom_range(0, 262143)) - 131072;
            s1_tab[k] = int'($urandom_range(0, 262143)) - 131072;
        end
        start_pulse();
        wait_done(de, fr);
        check("t1_done_edge", de, 16);
        check("t1_re0", re0, 7999);
        check("t1_im0", im0, 0);
        check("t1_pow0", pow0, 63984001);

        // Reset in the middle of FEED
        start_pulse();
        repeat (7) @(negedge CK);
        #2 RSTN = 1'b0;
        #1;
        check("t6_rd_en", rd_en, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_re0", re0, 0);
        check("t6_pow0", pow0, 0);
        @(negedge CK);
        RSTN = 1'b1;
        @(negedge CK);
        start_pulse();
        wait_done(de, fr);
        check("t6_done_edge", de, 16);
        check("t6_re0_after", re0, 7999);

        // Sign of the imaginary part
        set_tabs(1000, 0, 131071, 0, 0);
        start_pulse();
        wait_done(de, fr);
        check("t2_re0", re0, 0);
        check("t2_im0", im0, -8000);
        check("t2_re1", re1, 0);
        check("t2_im1", im1, 0);

        // Saturation both ways
        set_tabs(32767, 131071, 0, 0, 0);
        start_pulse();
        wait_done(de, fr);
        check("t3_re0_pos", re0, 131071);
        set_tabs(-32768, 131071, 0, 0, 0);
        start_pulse();
        wait_done(de, fr);
        check("t3_re0_neg", re0, -131072);
        check("t3_pow0", pow0, 64'd17179869184);

        // Sample/phase alignment
        set_tabs(0, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) x_tab[k] = k;
        c0_tab[3] = 131071;
        start_pulse();
        wait_done(de, fr);
        check("t4_re0", re0, 2);
        check("t4_first_rd", fr, LAT - 1);

        // Abort: restart at edge 6 must match a clean run
        rand_tabs();
        start_pulse();
        wait_done(de, fr);
        sv[0] = re0; sv[1] = im0; sv[2] = re1; sv[3] = im1; sv[4] = pow0;
        start_pulse();
        repeat (5) @(negedge CK);
        start_pulse();
        wait_done(de, fr);
        check("t5_done_edge", de, 16);
        check("t5_re0", re0, sv[0]);
        check("t5_im0", im0, sv[1]);
        check("t5_re1", re1, sv[2]);
        check("t5_im1", im1, sv[3]);
        check("t5_pow0", pow0, sv[4]);

        // START on the done edge
        rand_tabs();
        start_pulse();
        repeat (15) @(negedge CK);
        rand_tabs();
        start_pulse();
        check("b2b_done", done, 1);
        wait_done(de, fr);
        check("b2b_done_edge", de, 16);

        // Random frames, some aborted
        for (int f = 0; f < 10; f++) begin
            rand_tabs();
            start_pulse();
            if (f % 3 == 1) begin
                repeat ($urandom_range(1, 14)) @(negedge CK);
                rand_tabs();
                start_pulse();
            end
            wait_done(de, fr);
            check("rnd_done_edge", de, FIN);
            repeat ($urandom_range(0, 3)) @(negedge CK);
        end

        repeat (3) @(negedge CK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule
